// File: rtl/common_pkg.sv
// common_pkg: machine-wide constants and basic data types.
//   XLEN : integer register width
//   NREG : number of architectural integer registers (x0 reads as zero)
//   u64  : 64-bit unsigned data word
package common_pkg;

    localparam int XLEN = 64;
    localparam int NREG = 32;

    typedef logic [63:0] u64;

endpackage : common_pkg

// File: rtl/pipes_pkg.sv
// pipes_pkg: types shared between the decode, issue and writeback stages.
//   SB_CNT_W    : width of one pending-write counter
//   creg_addr_t : architectural register index (instr[19:15] / [24:20] / [11:7])
//   sb_cnt_t    : one pending-write counter value
//   wb_port_t   : everything the writeback stage drives in one bundle
package pipes_pkg;

    import common_pkg::*;

    localparam int SB_CNT_W = 2;
    localparam int CREG_W   = 5;

    typedef logic [CREG_W-1:0]   creg_addr_t;
    typedef logic [SB_CNT_W-1:0] sb_cnt_t;

    typedef struct packed {
        logic       valid;
        logic       wen;
        creg_addr_t dst;
        u64         data;
    } wb_port_t;

endpackage : pipes_pkg

// File: rtl/sb_counter.sv
// sb_counter: pending-write counter for one architectural register.
//   clk   : clock, updates on rising edge
//   reset : asynchronous, active-low; clears the count
//   flush : squash everything in flight; clears the count, beats inc/dec
//   inc   : an instruction writing this register issued this cycle
//   dec   : a write to this register retired this cycle
//   cnt   : current number of outstanding writes
// The count never wraps: increments at the maximum and decrements at zero
// are dropped. The top is expected to stall before either can happen.
module sb_counter #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (flush) begin
            cnt_d = '0;
        end else if (inc && !dec && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_ONE;
        end else if (dec && !inc && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule : sb_counter

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: integer register file (write side) with a per-register
// pending-write scoreboard for the decode stage.
//   clk, reset            : clock / asynchronous active-low reset
//   ra1, ra2              : decode read addresses
//   rd1, rd2              : read data, zero-latency, with writeback bypass
//   issue_valid/wen/dst   : instruction leaving decode and its destination
//   wb_valid/wen/dst/data : retiring instruction and its result
//   flush                 : squash all issued-but-not-retired instructions
//   stall                 : decode must hold this cycle
//   sb_error              : sticky, a writeback arrived with nothing pending
module regfile_scoreboard
    import pipes_pkg::*;
#(
    parameter int NREG  = common_pkg::NREG,
    parameter int XLEN  = common_pkg::XLEN,
    parameter int CNT_W = SB_CNT_W
) (
    input  logic            clk,
    input  logic            reset,
    input  creg_addr_t      ra1,
    input  creg_addr_t      ra2,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2,
    input  logic            issue_valid,
    input  logic            issue_wen,
    input  creg_addr_t      issue_dst,
    input  logic            wb_valid,
    input  logic            wb_wen,
    input  creg_addr_t      wb_dst,
    input  logic [XLEN-1:0] wb_data,
    input  logic            flush,
    output logic            stall,
    output logic            sb_error
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    wb_port_t wb;
    logic     wb_fire;

    assign wb = '{valid: wb_valid, wen: wb_wen, dst: wb_dst, data: wb_data};
    // x0 writes are dropped everywhere, so they never count as a retire.
    assign wb_fire = wb.valid && wb.wen && (wb.dst != '0);

    // ---------------- register array ----------------
    logic [XLEN-1:0] reg_q [NREG];
    logic [XLEN-1:0] reg_d [NREG];

    always_comb begin
        reg_d = reg_q;
        if (wb_fire) begin
            reg_d[wb.dst] = wb.data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) begin
                reg_q[i] <= '0;
            end
        end else begin
            reg_q <= reg_d;
        end
    end

    // Reads see a same-cycle writeback so a retire can release a stall
    // without waiting for the array update.
    always_comb begin
        rd1 = '0;
        if (ra1 != '0) begin
            rd1 = (wb_fire && (wb.dst == ra1)) ? wb.data : reg_q[ra1];
        end
    end

    always_comb begin
        rd2 = '0;
        if (ra2 != '0) begin
            rd2 = (wb_fire && (wb.dst == ra2)) ? wb.data : reg_q[ra2];
        end
    end

    // ---------------- scoreboard ----------------
    logic [CNT_W-1:0] cnt [NREG];
    logic [NREG-1:0]  dec;
    logic [NREG-1:0]  inc;

    assign cnt[0] = '0;

    // dec depends only on flopped counts and the writeback port, so it can
    // feed stall, which in turn masks inc, without forming a loop.
    always_comb begin
        dec = '0;
        for (int r = 1; r < NREG; r++) begin
            dec[r] = wb_fire && (wb.dst == creg_addr_t'(r)) && (cnt[r] != '0);
        end
    end

    always_comb begin
        inc = '0;
        for (int r = 1; r < NREG; r++) begin
            inc[r] = issue_valid && issue_wen && (issue_dst == creg_addr_t'(r)) && !stall;
        end
    end

    logic src1_pending;
    logic src2_pending;
    logic dst_full;

    // A source is clear when its last outstanding write retires this cycle;
    // the bypass above delivers that value.
    assign src1_pending = (ra1 != '0) && (cnt[ra1] != '0) &&
                          !((cnt[ra1] == CNT_ONE) && dec[ra1]);
    assign src2_pending = (ra2 != '0) && (cnt[ra2] != '0) &&
                          !((cnt[ra2] == CNT_ONE) && dec[ra2]);
    // A retire to the same destination frees a slot, so a full counter
    // only blocks when nothing is draining it this cycle.
    assign dst_full = issue_wen && (issue_dst != '0) &&
                      (cnt[issue_dst] == CNT_MAX) && !dec[issue_dst];

    assign stall = src1_pending || src2_pending || dst_full;

    for (genvar r = 1; r < NREG; r++) begin : g_cnt
        sb_counter #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk   (clk),
            .reset (reset),
            .flush (flush),
            .inc   (inc[r]),
            .dec   (dec[r]),
            .cnt   (cnt[r])
        );
    end

    // ---------------- sticky error ----------------
    logic sb_error_q;
    logic sb_error_d;

    always_comb begin
        sb_error_d = sb_error_q;
        if (wb_fire && (cnt[wb.dst] == '0)) begin
            sb_error_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sb_error_q <= 1'b0;
        end else begin
            sb_error_q <= sb_error_d;
        end
    end

    assign sb_error = sb_error_q;

endmodule : regfile_scoreboard

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Register-file write side, paired with the decode stage's reader.
- Holds the 32 x 64-bit integer registers.
- Accepts writeback writes and serves the two decode read ports with write-through bypass.
- Keeps a per-register pending-write scoreboard: instructions issue out of decode against it, and decode stalls while a source register has an outstanding write.

Parameters:
- NREG, 32, number of architectural registers (x0 hardwired zero).
- XLEN, 64, register data width.
- CNT_W, 2, width of each pending-write counter (max outstanding writes per register = 2^CNT_W - 1).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- ra1  in  5  decode read address 1 (instr[19:15]).
- ra2  in  5  decode read address 2 (instr[24:20]).
- rd1  out  XLEN  read data 1.
- rd2  out  XLEN  read data 2.
- issue_valid  in  1  decode hands an instruction to execute this cycle.
- issue_wen  in  1  the issued instruction writes a destination register.
- issue_dst  in  5  destination of the issued instruction (instr[11:7]).
- wb_valid  in  1  writeback stage retires an instruction this cycle.
- wb_wen  in  1  the retiring instruction writes the register file.
- wb_dst  in  5  writeback destination.
- wb_data  in  XLEN  writeback data.
- flush  in  1  squash all in-flight (issued, not yet retired) instructions.
- stall  out  1  decode must hold: a source is pending or the destination counter is full.
- sb_error  out  1  sticky: a writeback arrived for a register with no pending write.

Behaviour:
- Reset (reset=0, asynchronous):
  - all registers = 0, all counters = 0, sb_error = 0.
  - rd1/rd2 read 0; stall = 0.
- Write:
  - when wb_valid & wb_wen & wb_dst!=0, reg[wb_dst] <= wb_data at the edge.
  - writes to x0 are discarded.
- Read (combinational, zero latency):
  - rdN = 0 if raN==0.
  - else wb_data if wb_valid & wb_wen & wb_dst==raN (write-through bypass).
  - else reg[raN].
- Issue / retire terms, per register r (r!=0):
  - inc = issue_valid & issue_wen & issue_dst==r & ~stall.
  - dec = wb_valid & wb_wen & wb_dst==r & cnt[r]!=0.
- Counter update, per register:
  - inc & ~dec: cnt+1.
  - dec & ~inc: cnt-1.
  - both or neither: unchanged.
  - cnt[0] is always 0.
- Pending(r) = cnt[r]!=0 and not (cnt[r]==1 & dec for r this cycle). A retire in the same cycle clears the hazard, and the bypass supplies the data.
- stall:
  - asserted combinationally when (ra1!=0 & pending(ra1)) | (ra2!=0 & pending(ra2)), or when issue_wen & issue_dst!=0 & cnt[issue_dst]==max & no dec on issue_dst.
  - stall does not depend on issue_valid for source checks; decode gates issue_valid with ~stall externally.
  - internally, inc is also masked by stall.
- sb_error: set at the edge when wb_valid & wb_wen & wb_dst!=0 & cnt[wb_dst]==0. Held until reset. The data write still happens.
- flush:
  - all counters <= 0 at the edge, with priority over inc/dec.
  - a wb in the same cycle still writes data.
  - the flushing cycle's issue is not recorded.
  - stall is computed from pre-flush state in that cycle.
- Simultaneous issue and wb to the same rd with cnt==max: dec frees the slot, so no stall, and cnt is unchanged.
- Reset mid-operation clears everything immediately regardless of clk.

Decomposition:
- pipes package:
  - creg_addr_t (5 bits).
  - sb_cnt_t (CNT_W bits).
  - wb_port_t struct {valid, wen, dst, data}, so writeback drives one struct.
- common package: u64 and the XLEN/NREG constants.
- One sub-module: sb_counter (single saturating up/down counter with flush and reset), instantiated per register 1..NREG-1 in a generate loop.
- The register array and bypass muxes live in the top module.

Test Plan:
- Reset then ra1=5, ra2=0 -> rd1=0, rd2=0, stall=0, sb_error=0.
- wb writes x5=0xDEAD_BEEF; same cycle ra1=5 -> rd1=0xDEAD_BEEF (bypass). Next cycle, with wb idle -> rd1 still 0xDEAD_BEEF.
- Issue with dst=7. Next cycle ra2=7 -> stall=1. Cycle with wb to x7=0x42 -> stall=0 and rd2=0x42. Following cycle cnt[7]=0.
- Issue dst=3 three times (CNT_W=2, cnt=3), then issue dst=3 again -> stall=1, cnt stays 3. Same attempt with a wb to x3 that cycle -> stall=0, cnt stays 3.
- Issue dst=9, then flush -> cnt[9]=0, ra1=9 gives stall=0. A later wb to x9 -> sb_error=1, and it stays 1.
- wb writes x0=0x1234 -> ra1=0 reads 0, and sb_error is unchanged. Assert reset asynchronously mid-cycle -> all outputs return to 0 before the next clk edge.
